// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - key-store read bus between the key loader and the on-chip key store
interface key_load_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 4
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_data;
  logic              mem_par;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_data, mem_par
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_data, mem_par
  );
endinterface

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - fetches, parity-checks and atomically commits the key of a locked core
module key_load_ctrl #(
  parameter int KEY_BITS  = 12,
  parameter int WORD_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                relock,
  key_load_ctrl_if.master     mem,
  output logic [KEY_BITS-1:0] key_out,
  output logic                key_valid,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code
);
  localparam int NUM_WORDS = KEY_BITS / WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, GAP, COMMIT, LOADED, ERROR} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_BITS-1:0] shadow;

  logic             parity_ok;
  logic [IDX_W-1:0] next_idx;

  assign parity_ok = ^{mem.mem_data, mem.mem_par};
  assign next_idx  = idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      key_out      <= '0;
      key_valid    <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= BASE;
      busy         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else if (relock) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      key_out      <= '0;
      key_valid    <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= BASE;
      busy         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      case (state)
        // key_out/key_valid are left alone so a reload keeps the old key live
        IDLE, LOADED, ERROR: begin
          if (start) begin
            state        <= REQ;
            idx          <= '0;
            cnt          <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= BASE;
            busy         <= 1'b1;
            err          <= 1'b0;
            err_code     <= 2'b00;
          end
        end
        REQ: begin
          if (mem.mem_ack && parity_ok) begin
            shadow[idx*WORD_W +: WORD_W] <= mem.mem_data;
            mem.mem_req <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= COMMIT;
            end else begin
              idx          <= next_idx;
              mem.mem_addr <= BASE + ADDR_W'(next_idx);
              state        <= GAP;
            end
          end else if (mem.mem_ack || cnt == CNT_LAST) begin
            // a failed load must never leave any key, old or partial, applied
            state       <= ERROR;
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
            err_code    <= mem.mem_ack ? 2'b01 : 2'b10;
            key_out     <= '0;
            key_valid   <= 1'b0;
            shadow      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          state       <= REQ;
          cnt         <= '0;
          mem.mem_req <= 1'b1;
        end
        COMMIT: begin
          key_out   <= shadow;
          key_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= LOADED;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - directed self-checking bench for key_load_ctrl
module tb_key_load_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        relock;
  logic [11:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  key_load_ctrl_if #(.ADDR_W(4), .WORD_W(4)) bus ();

  key_load_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relock    (relock),
    .mem       (bus),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  logic [3:0] st_data [16];
  logic       st_par  [16];
  int         st_wait [16];

  int checks = 0;
  int errors = 0;

  int         n;
  logic [3:0] addr_q[$];
  int         hold_viol;
  int         stab_viol;
  logic       hold_on = 1'b0;
  logic [11:0] hold_key = '0;

  // key-store model: acks once mem_req has been visible for st_wait cycles
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    bus.mem_par  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_req) begin
        wcnt = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        bus.mem_par  = 1'b0;
      end else begin
        if (wcnt >= st_wait[bus.mem_addr]) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = st_data[bus.mem_addr];
          bus.mem_par  = st_par[bus.mem_addr];
        end else begin
          bus.mem_ack  = 1'b0;
        end
        wcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_store(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                           input logic good2, input int w1);
    for (int i = 0; i < 16; i++) begin
      st_data[i] = '0;
      st_par[i]  = 1'b1;
      st_wait[i] = 0;
    end
    st_data[0] = d0;
    st_data[1] = d1;
    st_data[2] = d2;
    for (int i = 0; i < 3; i++) st_par[i] = ~^st_data[i];
    if (!good2) st_par[2] = ~st_par[2];
    st_wait[1] = w1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // steps the clock until busy drops, logging request addresses and key hold
  task automatic wait_done();
    logic       prev_req;
    logic [3:0] prev_addr;
    n = 0;
    addr_q.delete();
    hold_viol = 0;
    stab_viol = 0;
    prev_req  = bus.mem_req;
    prev_addr = bus.mem_addr;
    if (bus.mem_req) addr_q.push_back(bus.mem_addr);
    while (busy && n < 60) begin
      tick();
      n++;
      if (bus.mem_req && !prev_req) addr_q.push_back(bus.mem_addr);
      if (bus.mem_req && prev_req && bus.mem_addr != prev_addr) stab_viol++;
      if (busy && hold_on && (key_out !== hold_key || key_valid !== 1'b1)) hold_viol++;
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; relock = 1'b0;
    set_store(4'h0, 4'h0, 4'h0, 1'b1, 0);
    tick(); tick();
    checks++; if (key_out !== 12'h000) begin errors++; $display("FAIL reset_key_out: got %h expected 000", key_out); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    checks++; if (busy !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_status: got busy=%b err=%b code=%b expected 0 0 00", busy, err, err_code); end
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 4'h0) begin errors++; $display("FAIL reset_bus: got req=%b addr=%h expected 0 0", bus.mem_req, bus.mem_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 0);
    hold_on = 1'b0;
    pulse_start();
    wait_done();
    checks++; if (n !== 6) begin errors++; $display("FAIL zw_latency: got %0d expected 6", n); end
    checks++; if (addr_q.size() != 3 || addr_q[0] !== 4'h0 || addr_q[1] !== 4'h1 || addr_q[2] !== 4'h2) begin errors++; $display("FAIL zw_addr_seq: got %p expected 0 1 2", addr_q); end
    checks++; if (key_out !== 12'h3A5 || key_valid !== 1'b1) begin errors++; $display("FAIL zw_key: got %h valid=%b expected 3a5 valid=1", key_out, key_valid); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL zw_after: got busy=%b err=%b expected 0 0", busy, err); end
  endtask

  task automatic test_delay();
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 4);
    pulse_start();
    wait_done();
    checks++; if (n !== 10) begin errors++; $display("FAIL dly_latency: got %0d expected 10", n); end
    checks++; if (stab_viol !== 0 || addr_q.size() != 3) begin errors++; $display("FAIL dly_bus_stable: got viol=%0d reqs=%0d expected 0 3", stab_viol, addr_q.size()); end
    checks++; if (err !== 1'b0 || key_out !== 12'h3A5 || key_valid !== 1'b1) begin errors++; $display("FAIL dly_result: got err=%b key=%h valid=%b expected 0 3a5 1", err, key_out, key_valid); end
  endtask

  task automatic test_parity_error();
    set_store(4'h5, 4'hA, 4'h3, 1'b0, 0);
    pulse_start();
    wait_done();
    checks++; if (n !== 5) begin errors++; $display("FAIL par_latency: got %0d expected 5", n); end
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL par_err: got err=%b code=%b expected 1 01", err, err_code); end
    checks++; if (key_out !== 12'h000 || key_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL par_locked: got key=%h valid=%b req=%b expected 000 0 0", key_out, key_valid, bus.mem_req); end
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 0);
    pulse_start();
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL par_retry_clear: got err=%b code=%b expected 0 00", err, err_code); end
    wait_done();
    checks++; if (key_out !== 12'h3A5 || key_valid !== 1'b1) begin errors++; $display("FAIL par_retry_key: got %h valid=%b expected 3a5 1", key_out, key_valid); end
  endtask

  task automatic test_timeout();
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 100);
    pulse_start();
    wait_done();
    checks++; if (n !== 17) begin errors++; $display("FAIL to_latency: got %0d expected 17", n); end
    checks++; if (err !== 1'b1 || err_code !== 2'b10 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_err: got err=%b code=%b req=%b expected 1 10 0", err, err_code, bus.mem_req); end
    checks++; if (key_out !== 12'h000 || key_valid !== 1'b0) begin errors++; $display("FAIL to_locked: got %h valid=%b expected 000 0", key_out, key_valid); end
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 14);
    pulse_start();
    wait_done();
    checks++; if (n !== 20) begin errors++; $display("FAIL to_last_ack_latency: got %0d expected 20", n); end
    checks++; if (err !== 1'b0 || key_out !== 12'h3A5 || key_valid !== 1'b1) begin errors++; $display("FAIL to_last_ack: got err=%b key=%h valid=%b expected 0 3a5 1", err, key_out, key_valid); end
  endtask

  task automatic test_reload_relock();
    set_store(4'h0, 4'hF, 4'h0, 1'b1, 0);
    hold_key = 12'h3A5;
    hold_on  = 1'b1;
    pulse_start();
    wait_done();
    hold_on = 1'b0;
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rl_hold: got %0d bad cycles expected 0", hold_viol); end
    checks++; if (n !== 6 || key_out !== 12'h0F0 || key_valid !== 1'b1) begin errors++; $display("FAIL rl_key: got n=%0d key=%h valid=%b expected 6 0f0 1", n, key_out, key_valid); end
    start = 1'b1; relock = 1'b1;
    tick();
    start = 1'b0; relock = 1'b0;
    checks++; if (key_out !== 12'h000 || key_valid !== 1'b0 || busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rl_relock_wins: got key=%h valid=%b busy=%b req=%b expected 000 0 0 0", key_out, key_valid, busy, bus.mem_req); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rl_idle: got busy=%b req=%b expected 0 0", busy, bus.mem_req); end
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 8);
    pulse_start();
    tick(); tick();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rl_mid_fetch: got req=%b busy=%b err=%b expected 0 0 0", bus.mem_req, busy, err); end
  endtask

  task automatic test_async_reset();
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 0);
    pulse_start();
    wait_done();
    set_store(4'h5, 4'hA, 4'h3, 1'b1, 6);
    pulse_start();
    tick(); tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 4'h1 || key_out !== 12'h3A5) begin errors++; $display("FAIL ar_pre: got req=%b addr=%h key=%h expected 1 1 3a5", bus.mem_req, bus.mem_addr, key_out); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL ar_bus: got req=%b addr=%h busy=%b expected 0 0 0", bus.mem_req, bus.mem_addr, busy); end
    checks++; if (key_out !== 12'h000 || key_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL ar_key: got key=%h valid=%b err=%b code=%b expected 000 0 0 00", key_out, key_valid, err, err_code); end
    tick();
    rst = 1'b0;
    tick();
    set_store(4'hC, 4'h1, 4'h6, 1'b1, 0);
    pulse_start();
    wait_done();
    checks++; if (n !== 6 || key_out !== 12'h61C || key_valid !== 1'b1) begin errors++; $display("FAIL ar_reload: got n=%0d key=%h valid=%b expected 6 61c 1", n, key_out, key_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delay();
    test_parity_error();
    test_timeout();
    test_reload_relock();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
- Sequences the key inputs of a locked combinational core such as the 12-key-bit c432 variant (s_0..s_11, two bits per obfuscated gate).
- Fetches the key word-by-word from an on-chip key store over a req/ack interface and checks odd parity per word.
- Commits the key atomically to key_out and holds key_out at zero (locked) until a fully verified key is present.
- Handles timeouts, parity errors, reload and relock.

Parameters:
- KEY_BITS, 12, total key width; drives s_0..s_(KEY_BITS-1), key_out[i] = s_i.
- WORD_W, 4, key-store data width; KEY_BITS must be a multiple of WORD_W.
- NUM_WORDS, KEY_BITS/WORD_W (3), derived localparam; words fetched per load.
- ADDR_W, 4, key-store address width.
- BASE_ADDR, 0, address of word 0; word i is read from BASE_ADDR+i.
- TIMEOUT, 15, maximum cycles mem_req may stay high without mem_ack.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a key load.
- relock  in  1  one-cycle pulse; clear the key and return to IDLE.
- mem_req  out  1  key-store read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  read complete; mem_data/mem_par valid in the same cycle.
- mem_data  in  WORD_W  key word.
- mem_par  in  1  odd-parity bit over mem_data.
- key_out  out  KEY_BITS  key applied to the locked core; word i occupies bits [i*WORD_W +: WORD_W].
- key_valid  out  1  key_out holds a verified key.
- busy  out  1  high in REQ, GAP and COMMIT.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 parity, 10 timeout.

Behaviour:
- Reset (async, rst=1): state=IDLE; word index=0; timeout count=0; shadow register=0; key_out=0; key_valid=0; mem_req=0; mem_addr=BASE_ADDR; busy=0; err=0; err_code=00.
- Reset asserted mid-load aborts immediately to these values. No partial key is ever exposed.
- States: IDLE, REQ, GAP, COMMIT, LOADED, ERROR.
- IDLE: start -> REQ with index=0; err and err_code cleared.
- REQ:
  - mem_req=1, mem_addr=BASE_ADDR+index; timeout count increments each cycle.
  - On mem_ack with XOR of {mem_data, mem_par} = 1: shadow word[index] <= mem_data. If index=NUM_WORDS-1 go to COMMIT; otherwise index++ and go to GAP.
  - On mem_ack with parity fail: go to ERROR with err_code=01.
  - No ack and count=TIMEOUT-1: go to ERROR with err_code=10. Ack in that same cycle takes priority over timeout.
  - Count resets on every REQ entry.
- GAP: mem_req=0 for exactly one cycle, then REQ. mem_ack during GAP is ignored.
- COMMIT: one cycle; key_out <= shadow and key_valid <= 1 at the exiting edge; next state LOADED.
- LOADED:
  - start -> REQ (reload). During reload key_out and key_valid keep the old key until the new COMMIT.
  - A reload that errors zeroes key_out and clears key_valid.
- ERROR: key_out=0, key_valid=0, err=1, mem_req=0. start retries (-> REQ, err cleared); relock -> IDLE with err cleared.
- relock in any non-reset state: key_out=0, key_valid=0, shadow=0, err=0, err_code=00, mem_req deasserted next cycle, state=IDLE. relock has priority over start and mem_ack in the same cycle.
- start while busy is ignored.
- All outputs are registered; mem_req is never combinationally dependent on mem_ack.
- Latency with zero-wait ack and NUM_WORDS=3: start sampled at edge E0; requests occupy cycles E0-E1, E2-E3, E4-E5; COMMIT occupies E5-E6; key_valid=1 after E6, i.e. 6 cycles.

Test Plan:
- Zero-wait store with words 0x5, 0xA, 0x3 (correct parity), pulse start -> mem_addr sequence 0, 1, 2; key_out=12'h3A5, key_valid=1 exactly 6 cycles after start; busy low afterwards.
- Ack delayed 4 cycles on word 1 -> mem_addr and mem_req held stable through the wait; key_valid rises 4 cycles later than the zero-wait case; err=0.
- Word 2 returned with bad parity -> err=1, err_code=01, key_out=0, key_valid=0; then start with good data -> err clears and key loads.
- Store never acks -> after TIMEOUT (15) cycles err_code=10, mem_req=0; ack arriving in the final counted cycle -> accepted, no error.
- LOADED with key 0x3A5, reload with 0x0F0 -> key_out stays 0x3A5 through the whole fetch, then switches to 0x0F0 in a single cycle; relock and start pulsed in the same cycle -> relock wins, key_out=0, state IDLE.
- rst asserted asynchronously mid-REQ on word 1 -> all outputs return to reset values immediately, before the next clk edge; no stale shadow bits appear on the next load.
